ntt_bank_mapper: RTL

Maps the butterfly index pairs produced by the k2 address generator into conflict-aware memory bank numbers and in-bank addresses for the multi-bank coefficient memory. It accepts one index pair per cycle with a valid/ready handshake. It computes each index's bank as the modular digit-sum of its `BANK_BITS`-wide fields, computes the row address, and flags same-bank pairs. It sits between the AGU and the memory-bank read/write arbiter, and counts pairs per pass with a one-cycle done pulse at the end of each pass.

---
 rtl/ntt_bank_mapper_if.sv | 34 +++
 rtl/ntt_bank_mapper.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ntt_bank_mapper_if.sv
// Handshake bundle between the k2 AGU (master) and the bank mapper (slave),
// carrying the index-pair request side and the mapped-pair response side.
interface ntt_bank_mapper_if #(
    parameter int D_WIDTH   = 12,
    parameter int BANK_BITS = 3,
    parameter int ADDR_W    = D_WIDTH - BANK_BITS
);
    logic                 in_valid;
    logic                 in_ready;
    logic [D_WIDTH-1:0]   in_idx0;
    logic [D_WIDTH-1:0]   in_idx1;
    logic                 in_last;

    logic                 out_valid;
    logic                 out_ready;
    logic [BANK_BITS-1:0] out_bank0;
    logic [BANK_BITS-1:0] out_bank1;
    logic [ADDR_W-1:0]    out_addr0;
    logic [ADDR_W-1:0]    out_addr1;
    logic                 out_conflict;
    logic                 out_last;

    modport master (
        output in_valid, in_idx0, in_idx1, in_last, out_ready,
        input  in_ready, out_valid, out_bank0, out_bank1,
               out_addr0, out_addr1, out_conflict, out_last
    );

    modport slave (
        input  in_valid, in_idx0, in_idx1, in_last, out_ready,
        output in_ready, out_valid, out_bank0, out_bank1,
               out_addr0, out_addr1, out_conflict, out_last
    );
endinterface

// File: rtl/ntt_bank_mapper.sv
// Maps butterfly index pairs to digit-sum banks and row addresses, flags same-bank pairs.
// Latency: 2 cycles (S1 partial sums, S2 banks/outputs); backpressure: 2-deep skid via per-stage valids.
// Backpressure: in_ready = !s1_valid || !s2_valid || out_ready; outputs hold while stalled.
module ntt_bank_mapper #(
    parameter int D_WIDTH   = 12,
    parameter int BANK_BITS = 3,
    parameter int ADDR_W    = D_WIDTH - BANK_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    ntt_bank_mapper_if.slave   bus,
    output logic [D_WIDTH-1:0] pair_cnt,
    output logic [D_WIDTH-1:0] pass_total,
    output logic [D_WIDTH-1:0] conflict_cnt,
    output logic               done
);

    localparam int NDIG  = (D_WIDTH + BANK_BITS - 1) / BANK_BITS;
    localparam int NLO   = NDIG / 2;
    localparam int PAD_W = NDIG * BANK_BITS;
    // Wide enough for NDIG digits that are all ones, so no carry is lost before the modulo.
    localparam int SUM_W = $clog2(NDIG * ((1 << BANK_BITS) - 1) + 1);

    function automatic logic [SUM_W-1:0] digit_sum(input logic [D_WIDTH-1:0] idx,
                                                   input int first_d,
                                                   input int end_d);
        logic [PAD_W-1:0] pad;
        logic [SUM_W-1:0] acc;
        pad = PAD_W'(idx);
        acc = '0;
        for (int d = 0; d < NDIG; d++) begin
            if (d >= first_d && d < end_d) begin
                acc = acc + SUM_W'(pad[d*BANK_BITS +: BANK_BITS]);
            end
        end
        return acc;
    endfunction

    logic                 s1_valid;
    logic                 s1_last;
    logic [ADDR_W-1:0]    s1_addr0;
    logic [ADDR_W-1:0]    s1_addr1;
    logic [SUM_W-1:0]     s1_lo0;
    logic [SUM_W-1:0]     s1_hi0;
    logic [SUM_W-1:0]     s1_lo1;
    logic [SUM_W-1:0]     s1_hi1;

    logic                 s2_valid;
    logic                 s2_last;
    logic                 s2_conflict;
    logic [BANK_BITS-1:0] s2_bank0;
    logic [BANK_BITS-1:0] s2_bank1;
    logic [ADDR_W-1:0]    s2_addr0;
    logic [ADDR_W-1:0]    s2_addr1;

    logic                 s2_adv;
    logic                 s1_adv;
    logic                 in_fire;
    logic                 out_fire;
    logic [BANK_BITS-1:0] bank0_c;
    logic [BANK_BITS-1:0] bank1_c;

    assign s2_adv   = !s2_valid || bus.out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = s2_valid && bus.out_ready;

    assign bus.in_ready = !s1_valid || s2_adv;

    // Both halves fit in SUM_W, so the truncating cast is exactly mod 2^BANK_BITS.
    always_comb begin
        bank0_c = BANK_BITS'(s1_lo0 + s1_hi0);
        bank1_c = BANK_BITS'(s1_lo1 + s1_hi1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_addr0 <= '0;
            s1_addr1 <= '0;
            s1_lo0   <= '0;
            s1_hi0   <= '0;
            s1_lo1   <= '0;
            s1_hi1   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (in_fire) begin
                s1_last  <= bus.in_last;
                s1_addr0 <= ADDR_W'(bus.in_idx0[D_WIDTH-1:BANK_BITS]);
                s1_addr1 <= ADDR_W'(bus.in_idx1[D_WIDTH-1:BANK_BITS]);
                s1_lo0   <= digit_sum(bus.in_idx0, 0, NLO);
                s1_hi0   <= digit_sum(bus.in_idx0, NLO, NDIG);
                s1_lo1   <= digit_sum(bus.in_idx1, 0, NLO);
                s1_hi1   <= digit_sum(bus.in_idx1, NLO, NDIG);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_last     <= 1'b0;
            s2_conflict <= 1'b0;
            s2_bank0    <= '0;
            s2_bank1    <= '0;
            s2_addr0    <= '0;
            s2_addr1    <= '0;
        end else begin
            if (s1_adv) begin
                s2_valid    <= 1'b1;
                s2_last     <= s1_last;
                s2_conflict <= (bank0_c == bank1_c);
                s2_bank0    <= bank0_c;
                s2_bank1    <= bank1_c;
                s2_addr0    <= s1_addr0;
                s2_addr1    <= s1_addr1;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.out_valid    = s2_valid;
        bus.out_last     = s2_last;
        bus.out_conflict = s2_conflict;
        bus.out_bank0    = s2_bank0;
        bus.out_bank1    = s2_bank1;
        bus.out_addr0    = s2_addr0;
        bus.out_addr1    = s2_addr1;
    end

    // Counting happens only at the output handshake, so a pair entering while
    // the last one leaves is naturally part of the next pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt     <= '0;
            pass_total   <= '0;
            conflict_cnt <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_fire && s2_last) begin
                pass_total   <= pair_cnt + 1'b1;
                pair_cnt     <= '0;
                conflict_cnt <= '0;
                done         <= 1'b1;
            end else if (out_fire) begin
                pair_cnt <= pair_cnt + 1'b1;
                if (s2_conflict && (conflict_cnt != '1)) begin
                    conflict_cnt <= conflict_cnt + 1'b1;
                end
            end
        end
    end

endmodule
